// File: rtl/run_ctrl.sv
// Run sequencer and watchdog for the stack processor: holds the DUT in reset,
// releases it, counts RUN cycles and reports pass (done seen) or fail (timeout).
module run_ctrl #(
    parameter int RST_CYCLES = 1,
    parameter int DONE_GUARD = 1,
    parameter int DRAIN      = 1,
    parameter int TIMEOUT    = 20,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_done,
    output logic             dut_reset,
    output logic             running,
    output logic [CNT_W-1:0] cycles,
    output logic             pass,
    output logic             fail
);

    // One counter serves both the RST hold and the DRAIN wait.
    localparam int PH_MAX = (RST_CYCLES > DRAIN) ? RST_CYCLES : DRAIN;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_PASS  = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cycles_r;
    logic [CNT_W-1:0]  cycles_s;
    logic [PH_W-1:0]   phase_r;
    logic [PH_W-1:0]   phase_s;
    logic              dut_reset_r;
    logic              running_r;
    logic              pass_r;
    logic              fail_r;
    logic              done_valid_s;
    logic              active_s;

    // dut_done only counts once the guard window after reset release has passed.
    assign done_valid_s = dut_done && (cycles_r > CNT_W'(DONE_GUARD));

    // Next-state, counter and next-output logic.
    always_comb begin
        state_s  = state_r;
        cycles_s = cycles_r;
        phase_s  = phase_r;
        case (state_r)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_s  = ST_RST;
                    cycles_s = {CNT_W{1'b0}};
                    phase_s  = {PH_W{1'b0}};
                end else begin
                    state_s  = state_r;
                end
            end
            ST_RST: begin
                if (phase_r == PH_W'(RST_CYCLES - 1)) begin
                    state_s  = ST_RUN;
                    cycles_s = CNT_W'(1);
                    phase_s  = {PH_W{1'b0}};
                end else begin
                    phase_s  = phase_r + PH_W'(1);
                end
            end
            ST_RUN: begin
                // A valid done in the timeout cycle still wins.
                if (done_valid_s) begin
                    phase_s = {PH_W{1'b0}};
                    if (DRAIN == 0) begin
                        state_s = ST_PASS;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else if (cycles_r == CNT_W'(TIMEOUT)) begin
                    state_s  = ST_FAIL;
                end else begin
                    cycles_s = cycles_r + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (phase_r == PH_W'(DRAIN - 1)) begin
                    state_s = ST_PASS;
                end else begin
                    phase_s = phase_r + PH_W'(1);
                end
            end
            default: begin
                state_s  = ST_IDLE;
                cycles_s = {CNT_W{1'b0}};
                phase_s  = {PH_W{1'b0}};
            end
        endcase
    end

    assign active_s = (state_s == ST_RUN) || (state_s == ST_DRAIN);

    // State, counters and registered outputs; synchronous active-low reset aborts any run.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cycles_r    <= {CNT_W{1'b0}};
            phase_r     <= {PH_W{1'b0}};
            dut_reset_r <= 1'b1;
            running_r   <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cycles_r    <= cycles_s;
            phase_r     <= phase_s;
            dut_reset_r <= ~active_s;
            running_r   <= active_s;
            pass_r      <= (state_s == ST_PASS);
            fail_r      <= (state_s == ST_FAIL);
        end
    end

    assign dut_reset = dut_reset_r;
    assign running   = running_r;
    assign cycles    = cycles_r;
    assign pass      = pass_r;
    assign fail      = fail_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a default-parameter instance driven from a
// vector table plus hand sequences, and a RST_CYCLES=3/DRAIN=0 instance.
module tb_run_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_start, a_done;
    logic        a_dut_reset, a_running, a_pass, a_fail;
    logic [15:0] a_cycles;
    logic        b_reset, b_start, b_done;
    logic        b_dut_reset, b_running, b_pass, b_fail;
    logic [15:0] b_cycles;

    run_ctrl u_a (
        .clk(clk), .reset(a_reset), .start(a_start), .dut_done(a_done),
        .dut_reset(a_dut_reset), .running(a_running), .cycles(a_cycles),
        .pass(a_pass), .fail(a_fail)
    );

    run_ctrl #(.RST_CYCLES(3), .DRAIN(0)) u_b (
        .clk(clk), .reset(b_reset), .start(b_start), .dut_done(b_done),
        .dut_reset(b_dut_reset), .running(b_running), .cycles(b_cycles),
        .pass(b_pass), .fail(b_fail)
    );

    // flags = {dut_reset, running, pass, fail}
    localparam logic [3:0] F_RST  = 4'b1000;
    localparam logic [3:0] F_RUN  = 4'b0100;
    localparam logic [3:0] F_PASS = 4'b1010;
    localparam logic [3:0] F_FAIL = 4'b1001;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        done;
        logic [3:0]  flags;
        logic [15:0] cyc;
    } vec_t;

    vec_t tbl [10];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic step_a(input logic r, input logic s, input logic d);
        a_reset = r; a_start = s; a_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic r, input logic s, input logic d);
        b_reset = r; b_start = s; b_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] gf, input logic [3:0] ef,
                       input logic [15:0] gc, input logic [15:0] ec);
        n_cmp++;
        if (gf !== ef || gc !== ec) begin
            n_bad++;
            $display("FAIL %s: got flags=%b cycles=%0d, expected flags=%b cycles=%0d",
                     nm, gf, gc, ef, ec);
        end
    endtask

    function automatic logic [3:0] fa();
        return {a_dut_reset, a_running, a_pass, a_fail};
    endfunction

    function automatic logic [3:0] fb();
        return {b_dut_reset, b_running, b_pass, b_fail};
    endfunction

    initial begin
        a_reset = 1'b0; a_start = 1'b0; a_done = 1'b0;
        b_reset = 1'b0; b_start = 1'b0; b_done = 1'b0;

        // T1: reset, start pulse, done on RUN cycle 5, one drain cycle, sticky PASS
        tbl[0] = '{1'b0, 1'b0, 1'b0, F_RST,  16'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, F_RST,  16'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, F_RUN,  16'd1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, F_RUN,  16'd2};
        tbl[4] = '{1'b1, 1'b0, 1'b0, F_RUN,  16'd3};
        tbl[5] = '{1'b1, 1'b0, 1'b0, F_RUN,  16'd4};
        tbl[6] = '{1'b1, 1'b0, 1'b0, F_RUN,  16'd5};
        tbl[7] = '{1'b1, 1'b0, 1'b1, F_RUN,  16'd5};
        tbl[8] = '{1'b1, 1'b0, 1'b0, F_PASS, 16'd5};
        tbl[9] = '{1'b1, 1'b0, 1'b0, F_PASS, 16'd5};
        for (int i = 0; i < 10; i++) begin
            step_a(tbl[i].rst_n, tbl[i].start, tbl[i].done);
            chk($sformatf("t1_row%0d", i), fa(), tbl[i].flags, a_cycles, tbl[i].cyc);
        end

        // T2: re-run from PASS, no done, start pulse mid-run ignored -> FAIL at 20
        step_a(1'b1, 1'b1, 1'b0); chk("t2_rst", fa(), F_RST, a_cycles, 16'd0);
        step_a(1'b1, 1'b0, 1'b0); chk("t2_run1", fa(), F_RUN, a_cycles, 16'd1);
        for (int k = 2; k <= 20; k++) begin
            step_a(1'b1, (k == 10), 1'b0);
            chk($sformatf("t2_run%0d", k), fa(), F_RUN, a_cycles, 16'(k));
        end
        step_a(1'b1, 1'b0, 1'b0); chk("t2_fail", fa(), F_FAIL, a_cycles, 16'd20);
        step_a(1'b1, 1'b0, 1'b0); chk("t2_fail_sticky", fa(), F_FAIL, a_cycles, 16'd20);

        // T3: done high from reset release; guard ignores RUN cycle 1
        step_a(1'b1, 1'b1, 1'b0); chk("t3_rst", fa(), F_RST, a_cycles, 16'd0);
        step_a(1'b1, 1'b0, 1'b1); chk("t3_run1", fa(), F_RUN, a_cycles, 16'd1);
        step_a(1'b1, 1'b0, 1'b1); chk("t3_guard", fa(), F_RUN, a_cycles, 16'd2);
        step_a(1'b1, 1'b0, 1'b1); chk("t3_drain", fa(), F_RUN, a_cycles, 16'd2);
        step_a(1'b1, 1'b0, 1'b1); chk("t3_pass", fa(), F_PASS, a_cycles, 16'd2);

        // T4: done arrives exactly on RUN cycle 20 -> beats timeout
        step_a(1'b1, 1'b1, 1'b0); chk("t4_rst", fa(), F_RST, a_cycles, 16'd0);
        step_a(1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= 20; k++) step_a(1'b1, 1'b0, 1'b0);
        chk("t4_run20", fa(), F_RUN, a_cycles, 16'd20);
        step_a(1'b1, 1'b0, 1'b1); chk("t4_drain", fa(), F_RUN, a_cycles, 16'd20);
        step_a(1'b1, 1'b0, 1'b0); chk("t4_pass", fa(), F_PASS, a_cycles, 16'd20);

        // T5: reset during RUN cycle 7 aborts to IDLE
        step_a(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) step_a(1'b1, 1'b0, 1'b0);
        chk("t5_run7", fa(), F_RUN, a_cycles, 16'd7);
        step_a(1'b0, 1'b0, 1'b0); chk("t5_abort", fa(), F_RST, a_cycles, 16'd0);
        step_a(1'b1, 1'b0, 1'b0); chk("t5_idle", fa(), F_RST, a_cycles, 16'd0);

        // T6: RST_CYCLES=3, DRAIN=0; PASS, then held start -> timeout, then one restart
        step_b(1'b0, 1'b0, 1'b0); chk("t6_reset", fb(), F_RST, b_cycles, 16'd0);
        step_b(1'b1, 1'b1, 1'b0); chk("t6_rst_a", fb(), F_RST, b_cycles, 16'd0);
        step_b(1'b1, 1'b0, 1'b0); chk("t6_rst_b", fb(), F_RST, b_cycles, 16'd0);
        step_b(1'b1, 1'b0, 1'b0); chk("t6_rst_c", fb(), F_RST, b_cycles, 16'd0);
        step_b(1'b1, 1'b0, 1'b0); chk("t6_run1", fb(), F_RUN, b_cycles, 16'd1);
        for (int k = 2; k <= 4; k++) step_b(1'b1, 1'b0, 1'b0);
        step_b(1'b1, 1'b0, 1'b1); chk("t6_pass", fb(), F_PASS, b_cycles, 16'd4);
        step_b(1'b1, 1'b1, 1'b0); chk("t6_rerun_rst", fb(), F_RST, b_cycles, 16'd0);
        step_b(1'b1, 1'b1, 1'b0); chk("t6_rerun_rst_b", fb(), F_RST, b_cycles, 16'd0);
        step_b(1'b1, 1'b1, 1'b0); chk("t6_rerun_rst_c", fb(), F_RST, b_cycles, 16'd0);
        step_b(1'b1, 1'b1, 1'b0); chk("t6_rerun_run1", fb(), F_RUN, b_cycles, 16'd1);
        for (int k = 2; k <= 20; k++) step_b(1'b1, 1'b1, 1'b0);
        chk("t6_run20", fb(), F_RUN, b_cycles, 16'd20);
        step_b(1'b1, 1'b1, 1'b0); chk("t6_fail", fb(), F_FAIL, b_cycles, 16'd20);
        step_b(1'b1, 1'b1, 1'b0); chk("t6_held_restart", fb(), F_RST, b_cycles, 16'd0);
        step_b(1'b1, 1'b0, 1'b0); chk("t6_restart_rst", fb(), F_RST, b_cycles, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
